// File: rtl/spi_controller_if.sv
// Host-side handshake and serial pins of the SPI initiator, bundled for port hookup.
interface spi_controller_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] txData;
    logic             miso;
    logic             sclk;
    logic             cs;
    logic             mosi;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] rxData;

    modport master (
        output start, txData, miso,
        input  sclk, cs, mosi, busy, done, rxData
    );

    modport slave (
        input  start, txData, miso,
        output sclk, cs, mosi, busy, done, rxData
    );
endinterface

// File: rtl/spi_controller.sv
// SPI mode-0 initiator: one MSB-first WIDTH-bit frame per accepted start,
// sclk half-period of HALF clk cycles, all outputs registered.
module spi_controller #(
    parameter int WIDTH = 8,
    parameter int HALF  = 4
) (
    input  logic             clk,
    input  logic             reset,
    spi_controller_if.slave  bus
);
    localparam int PW = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int BW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_t;

    state_t           r_state;
    logic [PW-1:0]    r_phase;
    logic [BW-1:0]    r_bit;
    logic [WIDTH-2:0] r_tx;
    logic [WIDTH-1:0] r_rx;
    logic             r_sclk;
    logic             r_cs;
    logic             r_mosi;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_rx_data;

    logic w_phase_end;
    logic w_last;

    assign w_phase_end = (r_phase == PW'(HALF - 1));
    // r_bit counts rising edges taken so far; WIDTH means every bit is in.
    assign w_last      = (r_bit == BW'(WIDTH));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_phase   <= '0;
            r_bit     <= '0;
            r_tx      <= '0;
            r_rx      <= '0;
            r_sclk    <= 1'b0;
            r_cs      <= 1'b1;
            r_mosi    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_rx_data <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_state <= SETUP;
                        r_phase <= '0;
                        r_bit   <= '0;
                        // MSB goes straight to mosi; the shifter keeps the rest.
                        r_tx    <= bus.txData[WIDTH-2:0];
                        r_mosi  <= bus.txData[WIDTH-1];
                        r_sclk  <= 1'b0;
                        r_cs    <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                HIGH: begin
                    if (w_phase_end) begin
                        r_phase <= '0;
                        r_state <= LOW;
                        r_sclk  <= 1'b0;
                        if (!w_last) begin
                            r_mosi <= r_tx[WIDTH-2];
                            r_tx   <= r_tx << 1;
                        end
                    end else begin
                        r_phase <= r_phase + PW'(1);
                    end
                end
                default: begin
                    // SETUP and LOW both end in a rising edge unless the frame is complete.
                    if (w_phase_end) begin
                        r_phase <= '0;
                        if (w_last) begin
                            r_state   <= IDLE;
                            r_cs      <= 1'b1;
                            r_mosi    <= 1'b0;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                            r_rx_data <= r_rx;
                        end else begin
                            r_state <= HIGH;
                            r_sclk  <= 1'b1;
                            r_rx    <= {r_rx[WIDTH-2:0], bus.miso};
                            r_bit   <= r_bit + BW'(1);
                        end
                    end else begin
                        r_phase <= r_phase + PW'(1);
                    end
                end
            endcase
        end
    end

    assign bus.sclk   = r_sclk;
    assign bus.cs     = r_cs;
    assign bus.mosi   = r_mosi;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.rxData = r_rx_data;
endmodule
